// File: rtl/led_burst_ctrl_if.sv
// Burst-request handshake bundle between a requester and led_burst_ctrl.
// The requester drives valid/len/mode; the controller answers with ready.
interface led_burst_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_len;
    logic [1:0] req_mode;

    modport master (
        output req_valid,
        output req_len,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_len,
        input  req_mode,
        output req_ready
    );
endinterface

// File: rtl/led_burst_ctrl.sv
// Timed LED burst sequencer: prescales clk into step ticks and steps a 4-bit pattern.
// Optional abort input is enabled with macro LED_BURST_ABORT_EN.
module led_burst_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    led_burst_ctrl_if.slave  req_if,
`ifdef LED_BURST_ABORT_EN
    input  logic             abort,
`endif
    output logic [3:0]       led,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] led_q, led_d;
    logic [7:0] presc_q, presc_d;
    logic [3:0] step_q, step_d;
    logic [3:0] len_q, len_d;
    logic [1:0] mode_q, mode_d;

    logic       tick;
    logic       abort_req;
    logic [3:0] led_init;
    logic [3:0] led_next;

    assign tick = (presc_q == 8'(DIV - 1));

`ifdef LED_BURST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        led_init = 4'h0;
        unique case (req_if.req_mode)
            2'd0:    led_init = 4'h0;
            2'd1:    led_init = 4'hF;
            2'd2:    led_init = 4'b0001;
            default: led_init = 4'b0101;
        endcase
    end

    always_comb begin
        led_next = led_q;
        unique case (mode_q)
            2'd0:    led_next = led_q + 4'd1;
            2'd1:    led_next = led_q - 4'd1;
            2'd2:    led_next = {led_q[2:0], led_q[3]};
            default: led_next = ~led_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        presc_d = presc_q;
        step_d  = step_q;
        len_d   = len_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (req_if.req_valid) begin
                    len_d   = req_if.req_len;
                    mode_d  = req_if.req_mode;
                    presc_d = 8'd0;
                    step_d  = 4'd0;
                    if (req_if.req_len == 4'd0) begin
                        state_d = StDone;
                        led_d   = 4'h0;
                    end else begin
                        state_d = StRun;
                        led_d   = led_init;
                    end
                end
            end
            StRun: begin
                // Abort wins over a coincident tick: the pattern freezes where it is.
                if (abort_req) begin
                    state_d = StDone;
                end else if (tick) begin
                    presc_d = 8'd0;
                    step_d  = step_q + 4'd1;
                    led_d   = led_next;
                    if (step_d == len_q) begin
                        state_d = StDone;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            StDone: begin
                led_d   = 4'h0;
                state_d = StIdle;
            end
            default: begin
                led_d   = 4'h0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            led_q   <= 4'h0;
            presc_q <= 8'd0;
            step_q  <= 4'd0;
            len_q   <= 4'd0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
        end
    end

    assign req_if.req_ready = (state_q == StIdle);
    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
    assign led              = led_q;

endmodule

// File: tb/tb_led_burst_ctrl.sv
// Directed self-checking bench for led_burst_ctrl at DIV=4, DIV=1 and DIV=2.
// Honours LED_BURST_ABORT_EN for the abort scenario.
module tb_led_burst_ctrl;

    logic clk;
    logic n_rst;
    int   tests_run;
    int   tests_failed;

    led_burst_ctrl_if if4 ();
    led_burst_ctrl_if if1 ();
    led_burst_ctrl_if if2 ();

    logic [3:0] led4, led1, led2;
    logic       busy4, busy1, busy2;
    logic       done4, done1, done2;
    logic       abort4, abort1, abort2;

    led_burst_ctrl #(.DIV(4)) u_div4 (
        .clk    (clk),
        .n_rst  (n_rst),
        .req_if (if4),
`ifdef LED_BURST_ABORT_EN
        .abort  (abort4),
`endif
        .led    (led4),
        .busy   (busy4),
        .done   (done4)
    );

    led_burst_ctrl #(.DIV(1)) u_div1 (
        .clk    (clk),
        .n_rst  (n_rst),
        .req_if (if1),
`ifdef LED_BURST_ABORT_EN
        .abort  (abort1),
`endif
        .led    (led1),
        .busy   (busy1),
        .done   (done1)
    );

    led_burst_ctrl #(.DIV(2)) u_div2 (
        .clk    (clk),
        .n_rst  (n_rst),
        .req_if (if2),
`ifdef LED_BURST_ABORT_EN
        .abort  (abort2),
`endif
        .led    (led2),
        .busy   (busy2),
        .done   (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        if ({led4, if4.req_ready, busy4, done4} !== 7'b0000_100) begin
            $display("FAIL reset_div4 got led=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                     led4, if4.req_ready, busy4, done4);
            tests_failed++;
        end
        tests_run++;
        if ({led1, if1.req_ready, busy1, done1} !== 7'b0000_100) begin
            $display("FAIL reset_div1 got led=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                     led1, if1.req_ready, busy1, done1);
            tests_failed++;
        end
        tests_run++;
        if ({led2, if2.req_ready, busy2, done2} !== 7'b0000_100) begin
            $display("FAIL reset_div2 got led=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                     led2, if2.req_ready, busy2, done2);
            tests_failed++;
        end
        tests_run++;
    endtask

    // DIV=4, len=3, mode 0: led counts 0,1,2,3 at E0, +4, +8, +12.
    task automatic test_up_count();
        logic [3:0] exp_led;
        if4.req_valid = 1'b1;
        if4.req_len   = 4'd3;
        if4.req_mode  = 2'd0;
        tick();
        if4.req_valid = 1'b0;
        if ({led4, if4.req_ready, busy4, done4} !== 7'b0000_010) begin
            $display("FAIL up_accept got led=%b rdy=%b busy=%b done=%b want 0000 0 1 0",
                     led4, if4.req_ready, busy4, done4);
            tests_failed++;
        end
        tests_run++;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_led = 4'(c / 4);
            if (led4 !== exp_led || done4 !== (c == 12)) begin
                $display("FAIL up_step%0d got led=%h done=%b want led=%h done=%b",
                         c, led4, done4, exp_led, (c == 12));
                tests_failed++;
            end
            tests_run++;
        end
        tick();
        if ({led4, if4.req_ready, busy4, done4} !== 7'b0000_100) begin
            $display("FAIL up_end got led=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                     led4, if4.req_ready, busy4, done4);
            tests_failed++;
        end
        tests_run++;
    endtask

    // DIV=1, len=5, mode 2: a rotation every edge, five ticks.
    task automatic test_div1_rotate();
        logic [3:0] exp_seq [6];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        if1.req_valid = 1'b1;
        if1.req_len   = 4'd5;
        if1.req_mode  = 2'd2;
        tick();
        if1.req_valid = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (led1 !== exp_seq[c] || done1 !== (c == 5)) begin
                $display("FAIL rot_step%0d got led=%b done=%b want led=%b done=%b",
                         c, led1, done1, exp_seq[c], (c == 5));
                tests_failed++;
            end
            tests_run++;
            tick();
        end
        if ({led1, if1.req_ready, done1} !== 6'b0000_10) begin
            $display("FAIL rot_end got led=%b rdy=%b done=%b want 0000 1 0",
                     led1, if1.req_ready, done1);
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_len_zero();
        if4.req_valid = 1'b1;
        if4.req_len   = 4'd0;
        if4.req_mode  = 2'd2;
        tick();
        if4.req_valid = 1'b0;
        if ({led4, if4.req_ready, busy4, done4} !== 7'b0000_011) begin
            $display("FAIL len0_done got led=%b rdy=%b busy=%b done=%b want 0000 0 1 1",
                     led4, if4.req_ready, busy4, done4);
            tests_failed++;
        end
        tests_run++;
        tick();
        if ({led4, if4.req_ready, busy4, done4} !== 7'b0000_100) begin
            $display("FAIL len0_idle got led=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                     led4, if4.req_ready, busy4, done4);
            tests_failed++;
        end
        tests_run++;
    endtask

    // Mode 1, len=8 on DIV=4; stray request during RUN, then reset sampled at E0+9.
    task automatic test_midburst_reset();
        int done_seen;
        if4.req_valid = 1'b1;
        if4.req_len   = 4'd8;
        if4.req_mode  = 2'd1;
        tick();
        if4.req_valid = 1'b0;
        tick();
        tick();
        if4.req_valid = 1'b1;
        if4.req_len   = 4'd1;
        if4.req_mode  = 2'd0;
        if (if4.req_ready !== 1'b0) begin
            $display("FAIL stray_ready got %b want 0", if4.req_ready);
            tests_failed++;
        end
        tests_run++;
        tick();
        tick();
        if4.req_valid = 1'b0;
        if (led4 !== 4'hE || done4 !== 1'b0) begin
            $display("FAIL stray_tick1 got led=%h done=%b want led=e done=0", led4, done4);
            tests_failed++;
        end
        tests_run++;
        for (int c = 5; c <= 8; c++) tick();
        if (led4 !== 4'hD || busy4 !== 1'b1) begin
            $display("FAIL stray_tick2 got led=%h busy=%b want led=d busy=1", led4, busy4);
            tests_failed++;
        end
        tests_run++;
        n_rst = 1'b0;
        #3;
        if (led4 !== 4'hD || busy4 !== 1'b1) begin
            $display("FAIL sync_reset got led=%h busy=%b want led=d busy=1", led4, busy4);
            tests_failed++;
        end
        tests_run++;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        if ({led4, if4.req_ready, busy4, done4} !== 7'b0000_100) begin
            $display("FAIL mid_reset got led=%b rdy=%b busy=%b done=%b want 0000 1 0 0",
                     led4, if4.req_ready, busy4, done4);
            tests_failed++;
        end
        tests_run++;
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done4 === 1'b1) done_seen++;
        end
        if (done_seen !== 0) begin
            $display("FAIL mid_no_done got %0d done pulses want 0", done_seen);
            tests_failed++;
        end
        tests_run++;
    endtask

    // DIV=2, len=10, mode 3, abort asserted for edge E0+6.
    task automatic test_abort();
        if2.req_valid = 1'b1;
        if2.req_len   = 4'd10;
        if2.req_mode  = 2'd3;
        tick();
        if2.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        if (led2 !== 4'b0101) begin
            $display("FAIL abort_pre got led=%b want 0101", led2);
            tests_failed++;
        end
        tests_run++;
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
`ifdef LED_BURST_ABORT_EN
        if (led2 !== 4'b0101 || done2 !== 1'b1) begin
            $display("FAIL abort_done got led=%b done=%b want led=0101 done=1", led2, done2);
            tests_failed++;
        end
        tests_run++;
        tick();
        if ({led2, if2.req_ready, done2} !== 6'b0000_10) begin
            $display("FAIL abort_end got led=%b rdy=%b done=%b want 0000 1 0",
                     led2, if2.req_ready, done2);
            tests_failed++;
        end
        tests_run++;
`else
        if (led2 !== 4'b1010 || done2 !== 1'b0) begin
            $display("FAIL noabort_e6 got led=%b done=%b want led=1010 done=0", led2, done2);
            tests_failed++;
        end
        tests_run++;
        for (int c = 7; c <= 19; c++) tick();
        if (led2 !== 4'b1010 || done2 !== 1'b0) begin
            $display("FAIL noabort_e19 got led=%b done=%b want led=1010 done=0", led2, done2);
            tests_failed++;
        end
        tests_run++;
        tick();
        if (led2 !== 4'b0101 || done2 !== 1'b1) begin
            $display("FAIL noabort_done got led=%b done=%b want led=0101 done=1", led2, done2);
            tests_failed++;
        end
        tests_run++;
        tick();
        if ({led2, if2.req_ready, done2} !== 6'b0000_10) begin
            $display("FAIL noabort_end got led=%b rdy=%b done=%b want 0000 1 0",
                     led2, if2.req_ready, done2);
            tests_failed++;
        end
        tests_run++;
`endif
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        n_rst         = 1'b0;
        abort4        = 1'b0;
        abort1        = 1'b0;
        abort2        = 1'b0;
        if4.req_valid = 1'b0;
        if4.req_len   = 4'd0;
        if4.req_mode  = 2'd0;
        if1.req_valid = 1'b0;
        if1.req_len   = 4'd0;
        if1.req_mode  = 2'd0;
        if2.req_valid = 1'b0;
        if2.req_len   = 4'd0;
        if2.req_mode  = 2'd0;
        #1;
        test_reset();
        test_up_count();
        test_div1_rotate();
        test_len_zero();
        test_midburst_reset();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
